fuzz_vector_sequencer: RTL

//  Sequences stimulus vectors into a fuzz-generated DUT ("top") and collects its responses.

---
 rtl/fuzz_vector_sequencer_if.sv | 31 +++
 rtl/fuzz_vector_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fuzz_vector_sequencer_if.sv
// Stimulus/response bundle between the vector source and the sequencer.
// master = vector source / response consumer, slave = sequencer.
interface fuzz_vector_sequencer_if #(
  parameter int VEC_W = 84,
  parameter int Y_W   = 119
);
  logic             stim_valid;
  logic             stim_ready;
  logic [VEC_W-1:0] stim_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [Y_W-1:0]   rsp_data;

  modport master (
    output stim_valid,
    output stim_data,
    output rsp_ready,
    input  stim_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  stim_valid,
    input  stim_data,
    input  rsp_ready,
    output stim_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/fuzz_vector_sequencer.sv
// Buffers stimulus vectors, applies each to the fuzz DUT for HOLD cycles,
// captures y and returns it. Define SEQ_MISR_EN for a response signature.
module fuzz_vector_sequencer #(
  parameter int VEC_W = 84,
  parameter int Y_W   = 119,
  parameter int DEPTH = 4,
  parameter int HOLD  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  fuzz_vector_sequencer_if.slave bus,
  output logic [VEC_W-1:0]       o_dut_in,
  input  logic [Y_W-1:0]         i_dut_y,
  output logic                   o_busy,
  output logic [15:0]            o_vec_cnt
`ifdef SEQ_MISR_EN
  ,
  input  logic                   i_sig_clr,
  output logic [Y_W-1:0]         o_sig
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [HW-1:0] HOLD_L   = HW'(HOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CAPTURE,
    S_WAIT
  } state_t;

  logic [VEC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             r_stim_ready;

  state_t           r_state;
  logic [HW-1:0]    r_hold;
  logic [VEC_W-1:0] r_dut_in;
  logic             r_rsp_valid;
  logic [Y_W-1:0]   r_rsp_data;
  logic [15:0]      r_vec_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_hs;
  logic [AW:0]      w_cnt_nxt;
  logic [HW-1:0]    w_hold_nxt;
  logic [VEC_W-1:0] w_head;

  assign w_empty    = (r_cnt == '0);
  assign w_push     = bus.stim_valid & r_stim_ready;
  assign w_hs       = r_rsp_valid & bus.rsp_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_hold_nxt = r_hold + 1'b1;

  // A pop happens from IDLE, or straight out of WAIT on the handshake edge.
  assign w_pop = i_en & ~w_empty &
                 ((r_state == S_IDLE) |
                  ((r_state == S_WAIT) & w_hs));

  assign w_cnt_nxt = r_cnt
                   + (AW+1)'(w_push)
                   - (AW+1)'(w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_stim_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.stim_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_cnt        <= w_cnt_nxt;
      r_stim_ready <= (w_cnt_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_dut_in    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_vec_cnt   <= '0;
    end else begin
      if (w_pop) begin
        r_dut_in <= w_head;
        r_hold   <= '0;
      end
      if (w_hs) begin
        r_vec_cnt <= r_vec_cnt + 16'd1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_APPLY;
          end
        end
        S_APPLY: begin
          r_hold <= w_hold_nxt;
          if (w_hold_nxt == HOLD_L) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_rsp_data  <= i_dut_y;
          r_rsp_valid <= 1'b1;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (w_hs) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_pop ? S_APPLY : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_MISR_EN
  logic [Y_W-1:0] r_sig;

  // Clear wins over a capture landing on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sig <= '0;
    end else if (i_sig_clr) begin
      r_sig <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_sig <= {r_sig[Y_W-2:0], r_sig[Y_W-1]} ^ i_dut_y;
    end
  end

  assign o_sig = r_sig;
`endif

  assign bus.stim_ready = r_stim_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign o_dut_in       = r_dut_in;
  assign o_vec_cnt      = r_vec_cnt;
  assign o_busy         = (r_state != S_IDLE) | ~w_empty;

endmodule
